// File: rtl/instr_type.sv
`default_nettype none
// ============================================================================
// Module      : instr_type (package)
// Description : Load kind and load error encodings shared by the load unit.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_type;

    typedef enum logic [2:0] {
        lk_lb      = 3'd0,
        lk_lh      = 3'd1,
        lk_lw      = 3'd2,
        lk_lbu     = 3'd3,
        lk_lhu     = 3'd4,
        lk_invalid = 3'd7
    } load_kind_t;

    typedef enum logic [1:0] {
        le_none       = 2'd0,
        le_illegal    = 2'd1,
        le_misaligned = 2'd2,
        le_timeout    = 2'd3
    } load_err_t;

    // Errors detectable at accept time, before any memory access.
    function automatic load_err_t load_check(input load_kind_t kind, input logic [1:0] ea_lo);
        load_err_t err;
        err = le_none;
        case (kind)
            lk_lb, lk_lbu: err = le_none;
            lk_lh, lk_lhu: err = ea_lo[0] ? le_misaligned : le_none;
            lk_lw:         err = (ea_lo != 2'b00) ? le_misaligned : le_none;
            default:       err = le_illegal;
        endcase
        return err;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_unit_if
// Description : Request, memory and result channels of the load unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_unit_if;
    import instr_type::*;

    logic        in_valid;
    logic        in_ready;
    load_kind_t  kind;
    logic [31:0] base;
    logic [11:0] offset;
    logic [4:0]  rd;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    load_err_t   out_err;

    modport master (
        output in_valid, kind, base, offset, rd, mem_gnt, mem_rvalid, mem_rdata, out_ready,
        input  in_ready, mem_req, mem_addr, out_valid, out_data, out_rd, out_err
    );

    modport slave (
        input  in_valid, kind, base, offset, rd, mem_gnt, mem_rvalid, mem_rdata, out_ready,
        output in_ready, mem_req, mem_addr, out_valid, out_data, out_rd, out_err
    );

endinterface
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_extract
// Description : Byte/half lane select and sign/zero extension of read data.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extract
    import instr_type::*;
(
    input  load_kind_t  kind,
    input  logic [1:0]  ea_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'(rdata >> {ea_lo, 3'b000});
        w_half = 16'(rdata >> {ea_lo[1], 4'b0000});
        data   = '0;
        case (kind)
            lk_lb:   data = {{24{w_byte[7]}}, w_byte};
            lk_lbu:  data = {24'd0, w_byte};
            lk_lh:   data = {{16{w_half[15]}}, w_half};
            lk_lhu:  data = {16'd0, w_half};
            lk_lw:   data = rdata;
            default: data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_unit
// Description : Single-outstanding load unit: address generation, alignment
//               check, memory read with timeout and result extension.
// Revision    : 1.0 - initial release
// ============================================================================
module load_unit
    import instr_type::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    load_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    load_kind_t  r_kind;
    logic [31:0] r_ea;
    logic [31:0] r_data;
    logic [4:0]  r_rd;
    load_err_t   r_err;
    logic [7:0]  r_cnt;

    logic        w_accept;
    logic        w_timeout;
    logic [31:0] w_ea;
    logic [31:0] w_ext;
    load_err_t   w_chk_err;

    assign w_ea      = bus.base + {{20{bus.offset[11]}}, bus.offset};
    assign w_chk_err = load_check(bus.kind, w_ea[1:0]);
    assign w_accept  = bus.in_valid && (r_state == ST_IDLE);
    // r_cnt counts WAIT cycles already spent, so this is the last allowed one.
    assign w_timeout = (r_cnt == 8'(MEM_TIMEOUT - 1));

    load_extract u_extract (
        .kind  (r_kind),
        .ea_lo (r_ea[1:0]),
        .rdata (bus.mem_rdata),
        .data  (w_ext)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.mem_req   = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid)
                    w_state_nxt = (w_chk_err != le_none) ? ST_RESP : ST_REQ;
            end
            ST_REQ: begin
                bus.mem_req = 1'b1;
                if (bus.mem_gnt) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mem_rvalid || w_timeout) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_kind <= lk_lb;
            r_ea   <= '0;
            r_data <= '0;
            r_rd   <= '0;
            r_err  <= le_none;
            r_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_kind <= bus.kind;
                r_rd   <= bus.rd;
                r_ea   <= w_ea;
                r_err  <= w_chk_err;
                r_data <= '0;
            end
            if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
                if (bus.mem_rvalid) begin
                    r_data <= w_ext;
                    r_err  <= le_none;
                end else if (w_timeout) begin
                    r_data <= '0;
                    r_err  <= le_timeout;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign bus.mem_addr = {r_ea[31:2], 2'b00};
    assign bus.out_data = r_data;
    assign bus.out_rd   = r_rd;
    assign bus.out_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_unit
// Description : Randomised self-checking bench for load_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_unit;
    import instr_type::*;

    localparam int T = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    load_unit_if bus();

    load_unit #(.MEM_TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.kind       = lk_lb;
        bus.base       = '0;
        bus.offset     = '0;
        bus.rd         = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.out_ready  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"},  32'(bus.in_ready),  32'd1);
        check({tag, " mem_req"},   32'(bus.mem_req),   32'd0);
        check({tag, " mem_addr"},  bus.mem_addr,       32'd0);
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " out_data"},  bus.out_data,       32'd0);
        check({tag, " out_rd"},    32'(bus.out_rd),    32'd0);
        check({tag, " out_err"},   32'(bus.out_err),   32'(le_none));
    endtask

    // Reference: what a load of this kind/address returns given the word read.
    function automatic void model(input load_kind_t k, input logic [31:0] b, input logic [11:0] o,
                                  input logic [31:0] rdata, input int rv_dly,
                                  output logic [31:0] ea, output load_err_t err, output logic [31:0] data);
        int          so;
        int unsigned lane;
        logic [31:0] bytev, halfv;
        so    = (o >= 12'd2048) ? int'(o) - 4096 : int'(o);
        ea    = b + 32'(so);
        lane  = ea % 4;
        bytev = (rdata >> (8 * lane)) & 32'hFF;
        halfv = (rdata >> (16 * (lane / 2))) & 32'hFFFF;
        if (k == lk_invalid)                               err = le_illegal;
        else if ((k == lk_lh || k == lk_lhu) && ea % 2 != 0) err = le_misaligned;
        else if (k == lk_lw && lane != 0)                  err = le_misaligned;
        else if (rv_dly >= T)                              err = le_timeout;
        else                                               err = le_none;
        data = 32'd0;
        if (err == le_none) begin
            case (k)
                lk_lb:   data = (bytev >= 128)   ? bytev - 32'd256   : bytev;
                lk_lh:   data = (halfv >= 32768) ? halfv - 32'd65536 : halfv;
                lk_lbu:  data = bytev;
                lk_lhu:  data = halfv;
                lk_lw:   data = rdata;
                default: data = 32'd0;
            endcase
        end
    endfunction

    task automatic run_load(input string tag, input load_kind_t k, input logic [31:0] b,
                            input logic [11:0] o, input logic [4:0] r, input logic [31:0] rdata,
                            input int gnt_dly, input int rv_dly, input int rdy_dly);
        logic [31:0] ea, exp_data, addr_first, data_first;
        load_err_t   exp_err;
        int          exp_lat, exp_req, lat, req_cycles, wait_cycles, hold_bad;
        bit          gnt_sent, done, addr_stable;
        model(k, b, o, rdata, rv_dly, ea, exp_err, exp_data);
        if (exp_err == le_illegal || exp_err == le_misaligned) begin
            exp_lat = 1;
            exp_req = 0;
        end else begin
            exp_lat = (exp_err == le_timeout) ? gnt_dly + T + 2 : gnt_dly + rv_dly + 3;
            exp_req = gnt_dly + 1;
        end

        @(negedge clk);
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.kind     = k;
        bus.base     = b;
        bus.offset   = o;
        bus.rd       = r;

        lat = 0; req_cycles = 0; wait_cycles = 0;
        gnt_sent = 1'b0; done = 1'b0; addr_stable = 1'b1; addr_first = 'x;
        while (!done && lat < 60) begin
            @(negedge clk);
            bus.in_valid   = 1'b0;
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
            lat++;
            if (bus.out_valid) begin
                done = 1'b1;
            end else if (bus.mem_req) begin
                if (req_cycles == 0) addr_first = bus.mem_addr;
                else if (bus.mem_addr !== addr_first) addr_stable = 1'b0;
                // Spurious read data while requesting must be ignored.
                bus.mem_rvalid = 1'b1;
                if (req_cycles == gnt_dly) begin
                    bus.mem_gnt = 1'b1;
                    gnt_sent    = 1'b1;
                end
                req_cycles++;
            end else if (gnt_sent) begin
                if (wait_cycles == rv_dly) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rdata;
                end
                wait_cycles++;
            end
        end
        bus.mem_rvalid = 1'b0;
        if (!done) check({tag, " out_valid_bound"}, 32'd0, 32'd1);

        check({tag, " latency"},    32'(lat),        32'(exp_lat));
        check({tag, " req_cycles"}, 32'(req_cycles), 32'(exp_req));
        if (exp_req != 0) begin
            check({tag, " mem_addr"},    addr_first,        {ea[31:2], 2'b00});
            check({tag, " addr_stable"}, 32'(addr_stable),  32'd1);
        end
        check({tag, " out_data"}, bus.out_data,       exp_data);
        check({tag, " out_rd"},   32'(bus.out_rd),    32'(r));
        check({tag, " out_err"},  32'(bus.out_err),   32'(exp_err));

        // Hold the result with a competing request that must not be taken.
        data_first   = bus.out_data;
        hold_bad     = 0;
        bus.in_valid = 1'b1;
        bus.kind     = lk_invalid;
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.in_ready || bus.out_data !== data_first) hold_bad++;
        end
        check({tag, " hold_bad"}, 32'(hold_bad), 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check({tag, " post_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " post_in_ready"},  32'(bus.in_ready),  32'd1);

        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = $urandom;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check({tag, " stale_rvalid"}, {30'd0, bus.out_valid, bus.mem_req}, 32'd0);
    endtask

    load_kind_t kinds [6] = '{lk_lb, lk_lh, lk_lw, lk_lbu, lk_lhu, lk_invalid};

    initial begin
        idle_inputs();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check_reset_outputs("reset");

        run_load("lb_ex",     lk_lb,      32'h0000_1000, 12'h003, 5'd1,  32'h80FF_1234, 0, 0, 0);
        run_load("lhu_neg",   lk_lhu,     32'h0000_2000, 12'hFFE, 5'd2,  32'hBEEF_0000, 0, 0, 0);
        run_load("lw_misal",  lk_lw,      32'h0000_1001, 12'h000, 5'd3,  32'h1234_5678, 0, 0, 0);
        run_load("illegal",   lk_invalid, 32'h0000_1000, 12'h000, 5'd4,  32'h1234_5678, 0, 0, 0);
        run_load("backpress", lk_lw,      32'h0000_0040, 12'h004, 5'd5,  32'hCAFE_F00D, 4, 1, 3);
        run_load("timeout",   lk_lbu,     32'h0000_0100, 12'h001, 5'd6,  32'h0000_00AA, 0, T, 1);

        // Reset while waiting for read data; the late data must not surface.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.kind     = lk_lw;
        bus.base     = 32'h0000_3000;
        bus.offset   = 12'h000;
        bus.rd       = 5'd9;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.mem_gnt  = 1'b1;
        @(negedge clk);
        bus.mem_gnt  = 1'b0;
        rst          = 1'b0;
        @(negedge clk);
        rst            = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check_reset_outputs("rst_wait");
        run_load("after_rst", lk_lh, 32'h0000_3000, 12'h002, 5'd10, 32'h8001_7FFF, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] rb;
            rb = $urandom;
            if ($urandom_range(0, 1) == 1) rb[1:0] = 2'b00;
            run_load("rand", kinds[$urandom_range(0, 5)], rb, 12'($urandom), 5'($urandom),
                     $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                     int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
